// File: rtl/bus_pkg.sv
// bus_pkg: shared types, destination-ID helpers and target-mask decode for the bus arbiter.
package bus_pkg;
   typedef enum logic [1:0] {IDLE, GRANT, SEND} state_e;
   localparam logic [7:0] BROADCAST_ID = 8'hFF;
   function automatic int id_msb(input int w);
      return w - 1;
   endfunction
   function automatic int id_lsb(input int w);
      return w - 8;
   endfunction
   // Empty mask means the packet must be dropped (invalid or self-addressed).
   function automatic logic [15:0] target_mask(input logic [7:0] dst, input logic [3:0] src,
                                               input logic [7:0] bcast, input int n);
      logic [31:0] all;
      all = (32'd1 << n) - 32'd1;
      if (dst == bcast) return 16'(all & ~(32'd1 << src));
      if (32'(dst) < n && dst != {4'd0, src}) return 16'(32'd1 << dst);
      return '0;
   endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search for the first request after index last.
module rr_picker #(
   parameter int devices = 4,
   parameter int iw = $clog2(devices)
) (
   input  logic [devices-1:0] req,
   input  logic [iw-1:0]      last,
   output logic [iw-1:0]      idx,
   output logic               valid
);
   logic [iw-1:0] j;
   // Walk from farthest to nearest so the nearest request after last wins.
   always_comb begin
      idx = '0;
      valid = 1'b0;
      j = '0;
      for (int k = devices; k >= 1; k--) begin
         j = iw'((int'(last) + k) % devices);
         if (req[j]) begin
            idx = j;
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin pop/decode/push sequencer for the shared terminal bus.
// Define BUS_ARB_TIMEOUT_EN to drop packets stalled in SEND for timeout cycles.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int devices = 4,
   parameter int width = 16,
   parameter logic [7:0] broadcast = BROADCAST_ID
`ifdef BUS_ARB_TIMEOUT_EN
   , parameter int timeout = 16
`endif
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [devices-1:0]         pndng,
   input  logic [devices*width-1:0]   d_pop,
   input  logic [devices-1:0]         full,
   output logic [devices-1:0]         pop,
   output logic [devices-1:0]         push,
   output logic [width-1:0]           d_push,
   output logic                       busy,
   output logic                       drop
);
   localparam int iw = $clog2(devices);
   state_e state;
   logic [iw-1:0] sel, rr_last, idx;
   logic valid;
   logic [width-1:0] pkt;
   logic [width-1:0] words [devices];
   logic [devices-1:0] mask;
`ifdef BUS_ARB_TIMEOUT_EN
   logic [15:0] cnt;
`endif
   for (genvar i = 0; i < devices; i++) begin : g_words
      assign words[i] = d_pop[i*width +: width];
   end
   assign mask = devices'(target_mask(pkt[id_msb(width):id_lsb(width)], 4'(sel), broadcast, devices));
   rr_picker #(.devices(devices)) u_pick (.req(pndng), .last(rr_last), .idx(idx), .valid(valid));
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         rr_last <= iw'(devices - 1);
         sel <= '0;
         pkt <= '0;
         pop <= '0;
         push <= '0;
         d_push <= '0;
         busy <= 1'b0;
         drop <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
         cnt <= '0;
`endif
      end else begin
         pop <= '0;
         push <= '0;
         drop <= 1'b0;
         case (state)
            IDLE: if (valid) begin
               sel <= idx;
               rr_last <= idx;
               pop <= devices'(1) << idx;
               busy <= 1'b1;
               state <= GRANT;
            end
            GRANT: begin
               pkt <= words[sel];
               state <= SEND;
`ifdef BUS_ARB_TIMEOUT_EN
               cnt <= '0;
`endif
            end
            SEND: if (mask == '0) begin
               drop <= 1'b1;
               busy <= 1'b0;
               state <= IDLE;
            end else if ((mask & full) == '0) begin
               push <= mask;
               d_push <= pkt;
               busy <= 1'b0;
               state <= IDLE;
`ifdef BUS_ARB_TIMEOUT_EN
            end else if (cnt == 16'(timeout - 1)) begin
               drop <= 1'b1;
               busy <= 1'b0;
               state <= IDLE;
            end else begin
               cnt <= cnt + 16'd1;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed plus random checks of bus_arbiter against a transaction-level model.
module tb_bus_arbiter;
   logic clk = 1'b0, reset = 1'b1;
   logic [3:0] pndng = '0, full = '0;
   logic [15:0] words [4];
   logic [63:0] d_pop;
   logic [3:0] pop, push;
   logic [15:0] d_push;
   logic busy, drop;
   int total = 0, bad = 0;
   // reference model: phase 0 waiting, 1 popping, 2 delivering
   int ph, m_sel, m_last;
   logic [15:0] m_pkt;
   logic [3:0] e_pop, e_push;
   logic [15:0] e_dpush;
   logic e_busy, e_drop;
   int gidx[$], gcyc[$];
   int cyc = 0;

   assign d_pop = {words[3], words[2], words[1], words[0]};
   always #5 clk = ~clk;

   bus_arbiter dut (.clk(clk), .reset(reset), .pndng(pndng), .d_pop(d_pop), .full(full),
                    .pop(pop), .push(push), .d_push(d_push), .busy(busy), .drop(drop));

   function automatic logic [3:0] targets(input logic [15:0] p, input int src);
      int dst = int'(p[15:8]);
      if (dst == 255) return 4'hF & ~(4'(1) << src);
      if (dst < 4 && dst != src) return 4'(1) << dst;
      return 4'h0;
   endfunction

   task automatic model();
      e_pop = '0; e_push = '0; e_drop = 1'b0;
      if (reset) begin
         ph = 0; m_last = 3; e_dpush = '0; e_busy = 1'b0;
         return;
      end
      if (ph == 0) begin
         for (int k = 1; k <= 4 && ph == 0; k++)
            if (pndng[(m_last + k) % 4]) begin
               m_sel = (m_last + k) % 4; m_last = m_sel;
               e_pop = 4'(1) << m_sel; e_busy = 1'b1; ph = 1;
            end
      end else if (ph == 1) begin
         m_pkt = words[m_sel]; ph = 2;
      end else begin
         if (targets(m_pkt, m_sel) == 0) begin
            e_drop = 1'b1; e_busy = 1'b0; ph = 0;
         end else if ((targets(m_pkt, m_sel) & full) == 0) begin
            e_push = targets(m_pkt, m_sel); e_dpush = m_pkt; e_busy = 1'b0; ph = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model();
      @(negedge clk);
      cyc++;
      if (pop != 0) begin gidx.push_back($clog2(pop)); gcyc.push_back(cyc); end
      chk("pop", 32'(pop), 32'(e_pop));
      chk("push", 32'(push), 32'(e_push));
      chk("d_push", 32'(d_push), 32'(e_dpush));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("drop", 32'(drop), 32'(e_drop));
   endtask

   task automatic one_pkt(input int src, input logic [15:0] p);
      words[src] = p; pndng = 4'(1) << src;
      cycle();
      pndng = '0;
      cycle();
      cycle();
   endtask

   initial begin
      foreach (words[i]) words[i] = '0;
      reset = 1'b1;
      cycle(); cycle();
      chk("rst_pop", 32'(pop), 0);
      chk("rst_busy", 32'(busy), 0);
      reset = 1'b0;
      // single unicast from terminal 1 to 2
      words[1] = 16'h02AB; pndng = 4'b0010;
      cycle();
      chk("u_pop", 32'(pop), 32'h2);
      chk("u_busy1", 32'(busy), 1);
      pndng = '0;
      cycle();
      chk("u_busy2", 32'(busy), 1);
      cycle();
      chk("u_push", 32'(push), 32'h4);
      chk("u_dpush", 32'(d_push), 32'h02AB);
      chk("u_busy_end", 32'(busy), 0);
      chk("u_drop", 32'(drop), 0);
      // fairness after reset with everybody pending
      reset = 1'b1; cycle(); reset = 1'b0;
      for (int i = 0; i < 4; i++) words[i] = {8'((i + 1) % 4), 8'(i)};
      gidx.delete(); gcyc.delete();
      pndng = 4'hF;
      repeat (15) cycle();
      pndng = '0;
      repeat (4) cycle();
      chk("f_count", 32'(gidx.size()), 5);
      for (int k = 0; k < 5 && k < gidx.size(); k++) chk("f_order", 32'(gidx[k]), 32'(k % 4));
      for (int k = 1; k < 5 && k < gcyc.size(); k++) chk("f_gap", 32'(gcyc[k] - gcyc[k-1]), 3);
      // broadcast from terminal 2
      one_pkt(2, 16'hFF55);
      chk("b_push", 32'(push), 32'hB);
      chk("b_dpush", 32'(d_push), 32'hFF55);
      cycle();
      chk("b_single", 32'(push), 0);
      // stall on a full destination
      full = 4'b1000;
      one_pkt(0, 16'h0311);
      repeat (5) begin cycle(); chk("s_hold", 32'(push), 0); chk("s_busy", 32'(busy), 1); end
      full = '0;
      cycle();
      chk("s_push", 32'(push), 32'h8);
      chk("s_dpush", 32'(d_push), 32'h0311);
      // invalid and self destinations
      one_pkt(0, 16'h0711);
      chk("i_drop", 32'(drop), 1);
      chk("i_push", 32'(push), 0);
      cycle();
      chk("i_drop_pulse", 32'(drop), 0);
      one_pkt(1, 16'h01CD);
      chk("self_drop", 32'(drop), 1);
      chk("self_push", 32'(push), 0);
      // reset while stalled in SEND
      full = 4'b1000;
      one_pkt(0, 16'h0311);
      cycle();
      reset = 1'b1;
      cycle();
      chk("r_push", 32'(push), 0);
      chk("r_busy", 32'(busy), 0);
      chk("r_dpush", 32'(d_push), 0);
      reset = 1'b0; full = '0; pndng = 4'b1010;
      cycle();
      chk("r_grant", 32'(pop), 32'h2);
      pndng = '0;
      repeat (3) cycle();
      // random traffic
      for (int n = 0; n < 600; n++) begin
         pndng = 4'($urandom);
         full = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         reset = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 5))
               0: words[i] = {8'hFF, 8'($urandom)};
               1: words[i] = {8'($urandom_range(4, 254)), 8'($urandom)};
               default: words[i] = {8'($urandom_range(0, 3)), 8'($urandom)};
            endcase
         end
         cycle();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
